// File: rtl/pht_update_unit_pkg.sv
// Shared fetch-side branch predictor types: PHT/GHR widths, update queue entry,
// counter encoding and the gshare / saturating-counter helpers.
package pht_update_unit_pkg;

  localparam int RESOLVE_WIDTH   = 2;
  localparam int QUEUE_DEPTH     = 8;
  localparam int PHT_INDEX_WIDTH = 11;
  localparam int GHR_WIDTH       = 10;
  localparam int QPTR_WIDTH      = $clog2(QUEUE_DEPTH);
  localparam int QCOUNT_WIDTH    = QPTR_WIDTH + 1;

  typedef logic [PHT_INDEX_WIDTH-1:0] PHT_IndexPath;
  typedef logic [GHR_WIDTH-1:0]       BranchGlobalHistoryPath;
  typedef logic [1:0]                 PHT_EntryPath;

  typedef enum logic [1:0] {
    PHT_STRONG_NT = 2'b00,
    PHT_WEAK_NT   = 2'b01,
    PHT_WEAK_T    = 2'b10,
    PHT_STRONG_T  = 2'b11
  } pht_counter_e;

  typedef struct packed {
    PHT_IndexPath index;
    logic         taken;
  } PHT_UpdateEntry;

  typedef enum logic {
    UPD_IDLE    = 1'b0,
    UPD_RD_WAIT = 1'b1
  } upd_state_e;

  function automatic PHT_IndexPath gshare_index(input logic [31:0] pc,
                                                input BranchGlobalHistoryPath ghr);
    return pc[PHT_INDEX_WIDTH+1:2] ^ PHT_IndexPath'(ghr);
  endfunction

  function automatic PHT_EntryPath counter_next(input PHT_EntryPath cnt, input logic taken);
    PHT_EntryPath nxt;
    if (taken) begin
      if (cnt == PHT_STRONG_T) nxt = PHT_STRONG_T;
      else                     nxt = cnt + 2'd1;
    end else begin
      if (cnt == PHT_STRONG_NT) nxt = PHT_STRONG_NT;
      else                      nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pht_update_unit_if.sv
// Resolve bus, PHT port and GHR-restore signals of the PHT update unit.
interface pht_update_unit_if;
  import pht_update_unit_pkg::*;

  logic [RESOLVE_WIDTH-1:0]                 res_valid;
  logic [RESOLVE_WIDTH-1:0][31:0]           res_pc;
  BranchGlobalHistoryPath [RESOLVE_WIDTH-1:0] res_ghr;
  logic [RESOLVE_WIDTH-1:0]                 res_taken;
  logic [RESOLVE_WIDTH-1:0]                 res_is_cond;
  logic [RESOLVE_WIDTH-1:0]                 res_mispred;
  logic                                     res_ready;
  logic                                     pht_busy;
  logic                                     pht_rd_en;
  PHT_IndexPath                             pht_rd_addr;
  PHT_EntryPath                             pht_rd_data;
  logic                                     pht_wr_en;
  PHT_IndexPath                             pht_wr_addr;
  PHT_EntryPath                             pht_wr_data;
  logic                                     ghr_restore_valid;
  BranchGlobalHistoryPath                   ghr_restore_value;
  logic                                     update_dropped;
  logic [QCOUNT_WIDTH-1:0]                  queue_count;

  modport master (
    output res_valid, res_pc, res_ghr, res_taken, res_is_cond, res_mispred,
    output pht_busy, pht_rd_data,
    input  res_ready, pht_rd_en, pht_rd_addr, pht_wr_en, pht_wr_addr, pht_wr_data,
    input  ghr_restore_valid, ghr_restore_value, update_dropped, queue_count
  );

  modport slave (
    input  res_valid, res_pc, res_ghr, res_taken, res_is_cond, res_mispred,
    input  pht_busy, pht_rd_data,
    output res_ready, pht_rd_en, pht_rd_addr, pht_wr_en, pht_wr_addr, pht_wr_data,
    output ghr_restore_valid, ghr_restore_value, update_dropped, queue_count
  );

endinterface

// File: rtl/pht_update_queue.sv
// Multi-push, single-pop circular FIFO of pending PHT updates. Pushes are
// accepted in lane order while free slots (counted before any pop) remain.
module pht_update_queue
  import pht_update_unit_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic [RESOLVE_WIDTH-1:0]          push_valid,
  input  PHT_UpdateEntry [RESOLVE_WIDTH-1:0] push_entry,
  input  logic                              pop,
  output PHT_UpdateEntry                    head_entry,
  output logic                              empty,
  output logic [QCOUNT_WIDTH-1:0]           count,
  output logic                              dropped
);

  PHT_UpdateEntry          mem_r [QUEUE_DEPTH];
  logic [QPTR_WIDTH-1:0]   head_r;
  logic [QPTR_WIDTH-1:0]   tail_r;
  logic [QCOUNT_WIDTH-1:0] count_r;
  logic [QCOUNT_WIDTH-1:0] free_s;
  logic [QCOUNT_WIDTH-1:0] accepted_s;
  logic [RESOLVE_WIDTH-1:0] wr_en_s;
  logic [QPTR_WIDTH-1:0]   wr_ptr_s [RESOLVE_WIDTH];
  logic                    dropped_s;

  // Assign consecutive tail slots to qualifying lanes until the queue is full.
  always_comb begin
    free_s     = QCOUNT_WIDTH'(QUEUE_DEPTH) - count_r;
    accepted_s = '0;
    dropped_s  = 1'b0;
    wr_en_s    = '0;
    for (int i = 0; i < RESOLVE_WIDTH; i++) begin
      wr_ptr_s[i] = tail_r + accepted_s[QPTR_WIDTH-1:0];
      if (push_valid[i]) begin
        if (accepted_s < free_s) begin
          wr_en_s[i] = 1'b1;
          accepted_s = accepted_s + QCOUNT_WIDTH'(1);
        end else begin
          dropped_s = 1'b1;
        end
      end else begin
        wr_en_s[i] = 1'b0;
      end
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      tail_r  <= tail_r + accepted_s[QPTR_WIDTH-1:0];
      head_r  <= head_r + QPTR_WIDTH'(pop);
      count_r <= count_r + accepted_s - QCOUNT_WIDTH'(pop);
    end
  end

  // Entry storage; contents are qualified by the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RESOLVE_WIDTH; i++) begin
      if (wr_en_s[i]) mem_r[wr_ptr_s[i]] <= push_entry[i];
    end
  end

  assign head_entry = mem_r[head_r];
  assign empty      = (count_r == '0);
  assign count      = count_r;
  assign dropped    = dropped_s;

endmodule

// File: rtl/pht_update_unit.sv
// Queues resolved conditional branches and read-modify-writes the PHT 2-bit
// counters (gshare index); also emits the corrected GHR after a mispredict.
module pht_update_unit
  import pht_update_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  pht_update_unit_if.slave bus
);

  logic [RESOLVE_WIDTH-1:0]           push_valid_s;
  PHT_UpdateEntry [RESOLVE_WIDTH-1:0] push_entry_s;
  PHT_UpdateEntry                     head_entry_s;
  logic                               q_empty_s;
  logic [QCOUNT_WIDTH-1:0]            q_count_s;
  logic                               q_dropped_s;
  logic                               pop_s;

  upd_state_e     state_r;
  upd_state_e     state_next_s;
  PHT_UpdateEntry lat_entry_r;
  logic           rd_en_s;
  PHT_IndexPath   rd_addr_s;
  logic           wr_en_s;
  PHT_IndexPath   wr_addr_s;
  PHT_EntryPath   wr_data_s;

  logic                   restore_hit_s;
  BranchGlobalHistoryPath restore_value_s;
  logic                   restore_valid_r;
  BranchGlobalHistoryPath restore_value_r;

  // Hash each qualifying lane into its queue entry.
  always_comb begin
    for (int i = 0; i < RESOLVE_WIDTH; i++) begin
      push_valid_s[i]       = bus.res_valid[i] & bus.res_is_cond[i];
      push_entry_s[i].index = gshare_index(bus.res_pc[i], bus.res_ghr[i]);
      push_entry_s[i].taken = bus.res_taken[i];
    end
  end

  pht_update_queue u_queue (
    .clk        (clk),
    .rst        (rst),
    .push_valid (push_valid_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .head_entry (head_entry_s),
    .empty      (q_empty_s),
    .count      (q_count_s),
    .dropped    (q_dropped_s)
  );

  // Update FSM state and the head entry captured at read time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= UPD_IDLE;
      lat_entry_r <= '0;
    end else begin
      state_r <= state_next_s;
      if (rd_en_s) lat_entry_r <= head_entry_s;
      else         lat_entry_r <= lat_entry_r;
    end
  end

  // Read in IDLE when the port is free; write back and pop in RD_WAIT.
  always_comb begin
    state_next_s = state_r;
    rd_en_s      = 1'b0;
    rd_addr_s    = '0;
    wr_en_s      = 1'b0;
    wr_addr_s    = '0;
    wr_data_s    = 2'b00;
    pop_s        = 1'b0;
    case (state_r)
      UPD_IDLE: begin
        if (!q_empty_s && !bus.pht_busy) begin
          rd_en_s      = 1'b1;
          rd_addr_s    = head_entry_s.index;
          state_next_s = UPD_RD_WAIT;
        end else begin
          state_next_s = UPD_IDLE;
        end
      end
      UPD_RD_WAIT: begin
        wr_en_s      = 1'b1;
        wr_addr_s    = lat_entry_r.index;
        wr_data_s    = counter_next(bus.pht_rd_data, lat_entry_r.taken);
        pop_s        = 1'b1;
        state_next_s = UPD_IDLE;
      end
      default: begin
        state_next_s = UPD_IDLE;
      end
    endcase
  end

  // Lowest mispredicted lane wins: scan high to low so lower lanes overwrite.
  always_comb begin
    restore_hit_s   = 1'b0;
    restore_value_s = '0;
    for (int i = RESOLVE_WIDTH - 1; i >= 0; i--) begin
      if (bus.res_valid[i] && bus.res_mispred[i]) begin
        restore_hit_s = 1'b1;
        if (bus.res_is_cond[i]) restore_value_s = {bus.res_ghr[i][GHR_WIDTH-2:0], bus.res_taken[i]};
        else                    restore_value_s = bus.res_ghr[i];
      end else begin
        restore_hit_s = restore_hit_s;
      end
    end
  end

  // GHR restore pulse register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      restore_valid_r <= 1'b0;
      restore_value_r <= '0;
    end else begin
      restore_valid_r <= restore_hit_s;
      restore_value_r <= restore_hit_s ? restore_value_s : '0;
    end
  end

  assign bus.res_ready         = (q_count_s <= QCOUNT_WIDTH'(QUEUE_DEPTH - RESOLVE_WIDTH));
  assign bus.pht_rd_en         = rd_en_s;
  assign bus.pht_rd_addr       = rd_addr_s;
  assign bus.pht_wr_en         = wr_en_s;
  assign bus.pht_wr_addr       = wr_addr_s;
  assign bus.pht_wr_data       = wr_data_s;
  assign bus.ghr_restore_valid = restore_valid_r;
  assign bus.ghr_restore_value = restore_value_r;
  assign bus.update_dropped    = q_dropped_s;
  assign bus.queue_count       = q_count_s;

endmodule
